// File: rtl/router_sync.sv
// Address latch, write steering and per-channel read-timeout soft reset
// between the 1x3 router front end and its three output FIFOs.
module router_sync #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] data_in,
    input  logic       detect_add,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0] addr;
    logic [2:0] vld;
    logic [2:0] rd;
    logic [2:0] sr;

    assign vld = ~{empty_2, empty_1, empty_0};
    assign rd  = {read_enb_2, read_enb_1, read_enb_0};

    assign vld_out_0 = vld[0];
    assign vld_out_1 = vld[1];
    assign vld_out_2 = vld[2];

    assign soft_reset_0 = sr[0];
    assign soft_reset_1 = sr[1];
    assign soft_reset_2 = sr[2];

    // Resetn is active-high despite its name.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            addr <= 2'b00;
        end else if (detect_add) begin
            addr <= data_in;
        end
    end

    always_comb begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
        case (addr)
            2'b00: begin
                write_enb = {2'b00, write_enb_reg};
                fifo_full = full_0;
            end
            2'b01: begin
                write_enb = {1'b0, write_enb_reg, 1'b0};
                fifo_full = full_1;
            end
            2'b10: begin
                write_enb = {write_enb_reg, 2'b00};
                fifo_full = full_2;
            end
            default: begin
                write_enb = 3'b000;
                fifo_full = 1'b0;
            end
        endcase
    end

    // One independent idle-valid timer per output channel.
    for (genvar g = 0; g < 3; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or posedge resetn) begin
            if (resetn) begin
                cnt   <= '0;
                sr[g] <= 1'b0;
            end else if (!vld[g] || rd[g]) begin
                cnt   <= '0;
                sr[g] <= 1'b0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                sr[g] <= 1'b1;
            end else begin
                cnt   <= cnt + 1'b1;
                sr[g] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_router_sync.sv
// Self-checking bench for router_sync: directed scenarios plus a
// randomized run against a run-length reference model.
module tb_router_sync;

    localparam int TIMEOUT = 30;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] data_in;
    logic       detect_add;
    logic [2:0] full;
    logic [2:0] empty;
    logic       write_enb_reg;
    logic [2:0] rd;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic [2:0] vld;
    logic [2:0] sr;

    int tests = 0;
    int fails = 0;

    router_sync #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .data_in      (data_in),
        .detect_add   (detect_add),
        .full_0       (full[0]),
        .full_1       (full[1]),
        .full_2       (full[2]),
        .empty_0      (empty[0]),
        .empty_1      (empty[1]),
        .empty_2      (empty[2]),
        .write_enb_reg(write_enb_reg),
        .read_enb_0   (rd[0]),
        .read_enb_1   (rd[1]),
        .read_enb_2   (rd[2]),
        .write_enb    (write_enb),
        .fifo_full    (fifo_full),
        .vld_out_0    (vld[0]),
        .vld_out_1    (vld[1]),
        .vld_out_2    (vld[2]),
        .soft_reset_0 (sr[0]),
        .soft_reset_1 (sr[1]),
        .soft_reset_2 (sr[2])
    );

    always #5 clk = ~clk;

    // Reference: length of the current unbroken idle-valid run per channel;
    // a pulse follows every edge that completes a multiple of TIMEOUT.
    logic [1:0] m_addr;
    int         run [3];
    logic [2:0] m_sr;

    always @(posedge clk or posedge resetn) begin
        if (resetn) begin
            m_addr = 2'b00;
            m_sr   = 3'b000;
            for (int n = 0; n < 3; n++) run[n] = 0;
        end else begin
            if (detect_add) m_addr = data_in;
            for (int n = 0; n < 3; n++) begin
                if (!empty[n] && !rd[n]) begin
                    run[n]  = run[n] + 1;
                    m_sr[n] = (run[n] % TIMEOUT == 0);
                end else begin
                    run[n]  = 0;
                    m_sr[n] = 1'b0;
                end
            end
        end
    end

    function automatic logic [2:0] exp_we(logic [1:0] a, logic w);
        logic [2:0] one;
        one = 3'b001;
        if (!w || a == 2'b11) return 3'b000;
        return one << a;
    endfunction

    function automatic logic exp_full(logic [1:0] a, logic [2:0] f);
        if (a == 2'b11) return 1'b0;
        return f[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_addr(input logic [1:0] a);
        detect_add = 1'b1;
        data_in    = a;
        tick();
        detect_add = 1'b0;
        data_in    = 2'($urandom);
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        resetn        = 1'b0;
        write_enb_reg = 1'b1;
        #1;
        tests++;
        if (sr !== 3'b000) begin
            fails++;
            $display("FAIL reset_sr: got %b expected 000", sr);
        end
        tests++;
        if (write_enb !== 3'b001) begin
            fails++;
            $display("FAIL reset_we: got %b expected 001", write_enb);
        end
        tests++;
        if (vld !== 3'b000) begin
            fails++;
            $display("FAIL reset_vld: got %b expected 000", vld);
        end
        write_enb_reg = 1'b0;
        tick();
    endtask

    task automatic test_steering();
        logic [1:0] seq [4];
        logic [2:0] want;
        seq = '{2'b01, 2'b00, 2'b10, 2'b11};
        for (int i = 0; i < 4; i++) begin
            load_addr(seq[i]);
            write_enb_reg = 1'b0;
            for (int c = 0; c < 2; c++) begin
                tick();
                tests++;
                if (write_enb !== 3'b000) begin
                    fails++;
                    $display("FAIL steer_idle a=%b: got %b expected 000",
                             seq[i], write_enb);
                end
            end
            write_enb_reg = 1'b1;
            #1;
            case (seq[i])
                2'b00:   want = 3'b001;
                2'b01:   want = 3'b010;
                2'b10:   want = 3'b100;
                default: want = 3'b000;
            endcase
            tests++;
            if (write_enb !== want) begin
                fails++;
                $display("FAIL steer a=%b: got %b expected %b",
                         seq[i], write_enb, want);
            end
            write_enb_reg = 1'b0;
            #1;
            tests++;
            if (write_enb !== 3'b000) begin
                fails++;
                $display("FAIL steer_drop a=%b: got %b expected 000",
                         seq[i], write_enb);
            end
        end
    endtask

    task automatic test_fifo_full();
        for (int a = 0; a < 4; a++) begin
            load_addr(2'(a));
            for (int c = 0; c < 8; c++) begin
                if (c < 4) full = (a < 3) ? 3'(((c + 1) % 2) << a) : 3'b111;
                else       full = 3'($urandom);
                tick();
                tests++;
                if (fifo_full !== exp_full(2'(a), full)) begin
                    fails++;
                    $display("FAIL full a=%0d f=%b: got %b expected %b",
                             a, full, fifo_full, exp_full(2'(a), full));
                end
            end
        end
        full = 3'b000;
    endtask

    task automatic test_timeout();
        logic [2:0] want;
        empty = 3'b110;
        rd    = 3'b000;
        #1;
        tests++;
        if (vld !== 3'b001) begin
            fails++;
            $display("FAIL vld0: got %b expected 001", vld);
        end
        for (int k = 1; k <= 65; k++) begin
            tick();
            want = (k == 30 || k == 60) ? 3'b001 : 3'b000;
            tests++;
            if (sr !== want) begin
                fails++;
                $display("FAIL timeout edge=%0d: got %b expected %b",
                         k, sr, want);
            end
        end
        empty = 3'b111;
        tick();
    endtask

    task automatic test_read_restart();
        logic [2:0] want;
        empty = 3'b001;
        rd    = 3'b100;
        for (int k = 1; k <= 20; k++) begin
            tick();
            tests++;
            if (sr !== 3'b000) begin
                fails++;
                $display("FAIL restart_pre edge=%0d: got %b expected 000",
                         k, sr);
            end
        end
        rd = 3'b110;
        tick();
        rd = 3'b100;
        for (int k = 1; k <= 35; k++) begin
            tick();
            want = (k == 30) ? 3'b010 : 3'b000;
            tests++;
            if (sr !== want) begin
                fails++;
                $display("FAIL restart edge=%0d: got %b expected %b",
                         k, sr, want);
            end
        end
        empty = 3'b111;
        rd    = 3'b000;
        tick();
    endtask

    task automatic test_independence();
        int         st [3];
        logic [2:0] want;
        st = '{0, 7, 13};
        for (int t = 0; t < 100; t++) begin
            for (int n = 0; n < 3; n++) empty[n] = !(t >= st[n]);
            tick();
            want = 3'b000;
            for (int n = 0; n < 3; n++)
                want[n] = (t >= st[n]) && ((t - st[n] + 1) % TIMEOUT == 0);
            tests++;
            if (sr !== want) begin
                fails++;
                $display("FAIL indep t=%0d: got %b expected %b", t, sr, want);
            end
        end
        empty = 3'b111;
        tick();
        empty = 3'b000;
        repeat (15) tick();
        #2;
        resetn = 1'b1;
        #1;
        tests++;
        if (sr !== 3'b000) begin
            fails++;
            $display("FAIL midreset_sr: got %b expected 000", sr);
        end
        tick();
        resetn = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            tick();
            want = (k == 30) ? 3'b111 : 3'b000;
            tests++;
            if (sr !== want) begin
                fails++;
                $display("FAIL midreset edge=%0d: got %b expected %b",
                         k, sr, want);
            end
        end
        empty = 3'b111;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            detect_add    = ($urandom_range(0, 7) == 0);
            data_in       = 2'($urandom);
            write_enb_reg = 1'($urandom);
            full          = 3'($urandom);
            for (int n = 0; n < 3; n++) begin
                empty[n] = ($urandom_range(0, 59) == 0);
                rd[n]    = ($urandom_range(0, 39) == 0);
            end
            #1;
            tests++;
            if (write_enb !== exp_we(m_addr, write_enb_reg) ||
                fifo_full !== exp_full(m_addr, full) ||
                vld !== ~empty) begin
                fails++;
                $display("FAIL rand_comb i=%0d: got we=%b ff=%b v=%b expected we=%b ff=%b v=%b",
                         i, write_enb, fifo_full, vld,
                         exp_we(m_addr, write_enb_reg),
                         exp_full(m_addr, full), ~empty);
            end
            tick();
            tests++;
            if (sr !== m_sr) begin
                fails++;
                $display("FAIL rand_sr i=%0d: got %b expected %b",
                         i, sr, m_sr);
            end
        end
    endtask

    initial begin
        resetn        = 1'b1;
        data_in       = 2'b00;
        detect_add    = 1'b0;
        full          = 3'b000;
        empty         = 3'b111;
        write_enb_reg = 1'b0;
        rd            = 3'b000;
        test_reset();
        test_steering();
        test_fifo_full();
        test_timeout();
        test_read_restart();
        test_independence();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/router_sync.md
Name: router_sync

Overview:
- Synchroniser and control block between the router's input FSM/register and the three output FIFOs of a 1x3 router.
- Latches the destination address on header detection.
- Steers the write enable to the addressed FIFO and reports that FIFO's full status.
- Generates valid-out flags and per-channel soft resets when a destination does not read within a timeout window.

Parameters:
- TIMEOUT, 30, consecutive idle-valid cycles (valid high, no read) before a channel soft reset fires.
- CNT_W, 5, width of each timeout counter; must satisfy 2**CNT_W >= TIMEOUT.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-high reset; asserted when 1, despite the name.
- data_in  input  2  destination address from packet header: 00 = FIFO0, 01 = FIFO1, 10 = FIFO2, 11 = invalid.
- detect_add  input  1  header-detect strobe; loads data_in into the address register.
- full_0, full_1, full_2  input  1 each  full flags from FIFO0..2.
- empty_0, empty_1, empty_2  input  1 each  empty flags from FIFO0..2.
- write_enb_reg  input  1  write request from the FSM.
- read_enb_0, read_enb_1, read_enb_2  input  1 each  read enables from the output ports.
- write_enb  output  3  one-hot FIFO write enable; bit n drives FIFO n.
- fifo_full  output  1  full flag of the currently addressed FIFO.
- vld_out_0, vld_out_1, vld_out_2  output  1 each  FIFO n holds data.
- soft_reset_0, soft_reset_1, soft_reset_2  output  1 each  registered timeout soft-reset pulse to FIFO n.

Behaviour:

Reset (resetn=1, asynchronous):
- addr register = 2'b00.
- All three timeout counters = 0.
- soft_reset_0..2 = 0.

Address register:
- On a rising edge with detect_add=1, addr <= data_in.
- Otherwise addr holds its value.
- A new address is usable in the cycle after the detect_add edge. It persists across any number of cycles until the next detect_add.

write_enb (combinational):
- write_enb_reg=0 -> 3'b000.
- write_enb_reg=1 and addr=00 -> 001; addr=01 -> 010; addr=10 -> 100; addr=11 -> 000.

fifo_full (combinational):
- addr=00 -> full_0; addr=01 -> full_1; addr=10 -> full_2; addr=11 -> 0.
- Follows the full input in the same cycle and does not depend on write_enb_reg.

vld_out_n (combinational):
- vld_out_n = ~empty_n.

Soft reset, independent per channel n, on each rising edge:
- vld_out_n=0: counter_n <= 0, soft_reset_n <= 0.
- vld_out_n=1 and read_enb_n=1: counter_n <= 0, soft_reset_n <= 0.
- vld_out_n=1, read_enb_n=0, counter_n = TIMEOUT-1: soft_reset_n <= 1, counter_n <= 0.
- vld_out_n=1, read_enb_n=0, otherwise: counter_n <= counter_n + 1, soft_reset_n <= 0.

Soft reset timing:
- soft_reset_n rises after the 30th consecutive qualifying edge and is a one-cycle pulse.
- If the condition persists, the pulse repeats every 30 cycles.
- A single read_enb_n cycle or empty_n=1 anywhere in the window restarts the count.
- Channels never interact.

Other boundary rules:
- Inputs with X/undriven values are not required to produce defined outputs.
- Asserting reset mid-count clears the counter immediately.

Size: target implementation roughly 120-200 lines.

Test Plan:
- Reset: drive resetn=1 for one cycle then 0 -> soft_reset_0..2=0; with write_enb_reg=1, data_in untouched -> write_enb=001.
- Address steering: pulse detect_add with data_in=01, hold write_enb_reg=0 for two cycles, then raise write_enb_reg -> write_enb=010. Drop write_enb_reg -> 000. Repeat with 00 -> 001, 10 -> 100, 11 -> 000.
- fifo_full mux: addr=00; toggle full_0 1/0/1/0 on successive cycles -> fifo_full follows it each cycle. Toggle full_1 while addr=00 -> fifo_full stays 0. Repeat for full_1 and full_2. With addr=11, any full pattern -> fifo_full=0.
- Timeout: empty_0=0, read_enb_0=0 held -> vld_out_0=1; soft_reset_0=0 for 29 edges, =1 for exactly one cycle after the 30th edge, then 0; next pulse 30 cycles later.
- Read restarts count: empty_1=0, read_enb_1=0 for 20 cycles, pulse read_enb_1 for one cycle, then hold 0 -> soft_reset_1 first asserts 30 edges after the read pulse, not at cycle 30. empty_2=0 with read_enb_2 held 1 -> soft_reset_2 never asserts.
- Independence and mid-operation reset: all channels valid with no reads, started on different cycles -> each pulses on its own 30-cycle schedule. Assert resetn=1 at cycle 15 -> counters cleared, first pulse 30 edges after reset release.
